// File: rtl/strassen_seq.sv
// Batch sequencer for the Strassen / naive 2x2-block tile multiply datapath.
// Moore-decoded lane opcodes and enables, tile read strobe and dual write ports, with stall.
module strassen_seq #(
    parameter int unsigned N_ALU  = 10,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned TILE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [TILE_W-1:0]     num_tiles,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [N_ALU*OP_W-1:0] alu_op,
    output logic [N_ALU-1:0]      alu_en,
    output logic [1:0]            src_sel,
    output logic                  rd_en,
    output logic [TILE_W-1:0]     rd_addr,
    output logic                  mem_we,
    output logic [TILE_W+1:0]     wr_addr0,
    output logic [TILE_W+1:0]     wr_addr1
);
    localparam int unsigned NLanes = 10;
    localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
    localparam logic [OP_W-1:0] OpMult = OP_W'(2);

    typedef enum logic [2:0] {
        StIdle, StLoad, StPre, StMul, StPost1, StPost2, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] ntiles_q, ntiles_d;
    logic              mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            tile_q   <= '0;
            ntiles_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        ntiles_d = ntiles_q;
        mode_d   = mode_q;
        if (state_q == StIdle) begin
            if (start) begin
                mode_d   = mode;
                ntiles_d = num_tiles;
                tile_d   = '0;
                state_d  = (num_tiles == '0) ? StDone : StLoad;
            end
        end else if (!stall) begin
            unique case (state_q)
                StLoad:  state_d = mode_q ? StMul : StPre;
                StPre:   state_d = StMul;
                StMul:   state_d = StPost1;
                StPost1: state_d = StPost2;
                StPost2: begin
                    // ntiles_q is non-zero here, so the last index never wraps
                    if (tile_q == ntiles_q - TILE_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        tile_d  = tile_q + TILE_W'(1);
                        state_d = StLoad;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    logic [NLanes-1:0]           en10;
    logic [NLanes-1:0][OP_W-1:0] op10;

    always_comb begin
        en10 = '0;
        for (int i = 0; i < NLanes; i++) op10[i] = OpAdd;
        busy     = (state_q != StIdle);
        done     = 1'b0;
        src_sel  = 2'd0;
        rd_en    = 1'b0;
        mem_we   = 1'b0;
        rd_addr  = busy ? tile_q : '0;
        wr_addr0 = '0;
        wr_addr1 = '0;
        unique case (state_q)
            StIdle: ;
            StLoad: rd_en = 1'b1;
            StPre: begin
                en10    = '1;
                op10[0] = OpSub;
                op10[3] = OpSub;
                op10[6] = OpSub;
                op10[8] = OpSub;
            end
            StMul: begin
                if (mode_q) begin
                    en10 = 10'h0ff;
                    for (int i = 0; i < 8; i++) op10[i] = OpMult;
                end else begin
                    src_sel = 2'd1;
                    en10    = 10'h07f;
                    for (int i = 0; i < 7; i++) op10[i] = OpMult;
                end
            end
            StPost1: begin
                src_sel = 2'd2;
                mem_we  = 1'b1;
                if (mode_q) begin
                    en10     = 10'h003;
                    wr_addr0 = {tile_q, 2'd0};
                    wr_addr1 = {tile_q, 2'd1};
                end else begin
                    en10     = 10'h03f;
                    op10[1]  = OpSub;
                    wr_addr0 = {tile_q, 2'd1};
                    wr_addr1 = {tile_q, 2'd2};
                end
            end
            StPost2: begin
                mem_we = 1'b1;
                en10   = 10'h003;
                if (mode_q) begin
                    src_sel  = 2'd2;
                    wr_addr0 = {tile_q, 2'd2};
                    wr_addr1 = {tile_q, 2'd3};
                end else begin
                    src_sel  = 2'd3;
                    op10[1]  = OpSub;
                    wr_addr0 = {tile_q, 2'd0};
                    wr_addr1 = {tile_q, 2'd3};
                end
            end
            StDone: done = 1'b1;
            default: ;
        endcase
        // Stall suppresses strobes only; op, src_sel and addresses stay visible
        if (stall) begin
            rd_en  = 1'b0;
            mem_we = 1'b0;
            en10   = '0;
            done   = 1'b0;
        end
    end

    always_comb begin
        alu_op = '0;
        alu_op[NLanes*OP_W-1:0] = op10;
    end

    assign alu_en = N_ALU'(en10);

endmodule

// File: tb/tb_strassen_seq.sv
// Randomized scoreboard bench for strassen_seq: expected strobe records are queued per batch
// from the operation tables and popped by a monitor whenever the sequencer emits a strobe.
module tb_strassen_seq;
    localparam int unsigned N_ALU  = 12;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned TILE_W = 6;

    logic        clk = 1'b0;
    logic        rst_n, start, mode, stall;
    logic [5:0]  num_tiles;
    logic        busy, done, rd_en, mem_we;
    logic [35:0] alu_op;
    logic [11:0] alu_en;
    logic [1:0]  src_sel;
    logic [5:0]  rd_addr;
    logic [7:0]  wr_addr0, wr_addr1;

    always #5 clk = ~clk;

    strassen_seq #(.N_ALU(N_ALU), .OP_W(OP_W), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_tiles(num_tiles),
        .stall(stall), .busy(busy), .done(done), .alu_op(alu_op), .alu_en(alu_en),
        .src_sel(src_sel), .rd_en(rd_en), .rd_addr(rd_addr), .mem_we(mem_we),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic        we;
        logic [11:0] en;
        logic [35:0] op;
        logic [1:0]  src;
        logic [5:0]  ra;
        logic [7:0]  w0;
        logic [7:0]  w1;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sb_en    = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {busy, done, rd_en, mem_we, src_sel, alu_en, alu_op}, '0);
    endtask

    // One expected strobe cycle; sub/mul are lane masks, unset lanes are ADD
    function automatic rec_t mk(input logic rd, input logic we, input logic dn,
                                input logic [11:0] en, input logic [11:0] sub,
                                input logic [11:0] mul, input logic [1:0] src, input int t,
                                input logic [1:0] q0, input logic [1:0] q1);
        rec_t r;
        r      = '0;
        r.busy = 1'b1;
        r.done = dn;
        r.rd   = rd;
        r.we   = we;
        r.en   = en;
        for (int i = 0; i < 12; i++) r.op[i*3 +: 3] = sub[i] ? 3'd1 : (mul[i] ? 3'd2 : 3'd0);
        r.src = (en != 0 || rd) ? src : 2'd0;
        r.ra  = rd ? 6'(t) : 6'd0;
        r.w0  = we ? {6'(t), q0} : 8'd0;
        r.w1  = we ? {6'(t), q1} : 8'd0;
        return r;
    endfunction

    task automatic push_batch(input bit m, input int n);
        for (int t = 0; t < n; t++) begin
            exp_q.push_back(mk(1, 0, 0, 12'h000, 12'h000, 12'h000, 2'd0, t, 0, 0));
            if (!m) begin
                exp_q.push_back(mk(0, 0, 0, 12'h3ff, 12'h149, 12'h000, 2'd0, t, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 12'h07f, 12'h000, 12'h07f, 2'd1, t, 0, 0));
                exp_q.push_back(mk(0, 1, 0, 12'h03f, 12'h002, 12'h000, 2'd2, t, 1, 2));
                exp_q.push_back(mk(0, 1, 0, 12'h003, 12'h002, 12'h000, 2'd3, t, 0, 3));
            end else begin
                exp_q.push_back(mk(0, 0, 0, 12'h0ff, 12'h000, 12'h0ff, 2'd0, t, 0, 0));
                exp_q.push_back(mk(0, 1, 0, 12'h003, 12'h000, 12'h000, 2'd2, t, 0, 1));
                exp_q.push_back(mk(0, 1, 0, 12'h003, 12'h000, 12'h000, 2'd2, t, 2, 3));
            end
        end
        exp_q.push_back(mk(0, 0, 1, 12'h000, 12'h000, 12'h000, 2'd0, 0, 0, 0));
    endtask

    // Monitor: every strobe cycle must match the next queued record
    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        if (sb_en && rst_n && (rd_en || mem_we || alu_en != 0 || done)) begin
            a.busy = busy;
            a.done = done;
            a.rd   = rd_en;
            a.we   = mem_we;
            a.en   = alu_en;
            a.op   = alu_op;
            a.src  = (alu_en != 0 || rd_en) ? src_sel : 2'd0;
            a.ra   = rd_en ? rd_addr : 6'd0;
            a.w0   = mem_we ? wr_addr0 : 8'd0;
            a.w1   = mem_we ? wr_addr1 : 8'd0;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", a, '0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_rec", a, e);
            end
        end
    end

    // Entered and left inside an idle cycle, after its negedge
    task automatic run_batch(input bit m, input int n, input int sf, input int sl, input bit rnd);
        int cyc;
        int stalls;
        int base;
        bit seen;
        push_batch(m, n);
        base      = (n == 0) ? 1 : (m ? 4 * n + 1 : 5 * n + 1);
        start     = 1'b1;
        mode      = m;
        num_tiles = 6'(n);
        stall     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        start  = 1'b0;
        cyc    = 0;
        stalls = 0;
        seen   = 1'b0;
        while (!seen && cyc < 2000) begin
            cyc++;
            stall = (cyc >= sf && cyc < sf + sl) || (rnd && $urandom_range(0, 3) == 0);
            if (rnd && $urandom_range(0, 5) == 0) begin
                start     = 1'b1;
                mode      = 1'($urandom);
                num_tiles = 6'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (stall) stalls++;
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        check("done_seen", 128'(seen), 128'd1);
        check("done_cycle", 128'(cyc), 128'(base + stalls));
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_idle("idle_after_batch");
        check("sb_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        rst_n     = 1'b0;
        start     = 1'b1;
        stall     = 1'b1;
        mode      = 1'b1;
        num_tiles = 6'd5;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_idle("reset_idle");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check_idle("post_reset_idle");
        sb_en = 1'b1;

        run_batch(1'b0, 1, 0, 0, 1'b0);   // Strassen, 1 tile: done cycle 6
        run_batch(1'b1, 3, 0, 0, 1'b0);   // naive, 3 tiles: done cycle 13
        run_batch(1'b0, 2, 4, 3, 1'b0);   // stall through tile-0 POST1: done cycle 14
        run_batch(1'b0, 0, 0, 0, 1'b0);   // empty batch
        run_batch(1'b1, 0, 0, 0, 1'b1);
        run_batch(1'b0, 63, 0, 0, 1'b0);  // largest batch, last tile index 62

        // Reset during MUL aborts the batch with no done pulse
        sb_en     = 1'b0;
        start     = 1'b1;
        mode      = 1'b0;
        num_tiles = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_mul_en", 128'(alu_en), 128'h07f);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_idle");
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        check("abort_no_done", 128'(saw), 128'd0);
        sb_en = 1'b1;

        for (int b = 0; b < 25; b++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) :
                                              int'($urandom_range(0, 6));
            run_batch(1'($urandom), n, 0, 0, 1'b1);
        end

        check("final_drained", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
